mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data bus master: aligns stores, extends loads, flags address errors and
// stalls the pipeline until the bus transaction completes.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_master_mem_en,
  input  logic [5:0]  M_master_op,
  input  logic [31:0] M_master_alu_res,
  input  logic [31:0] M_master_rt_value,
  input  logic        flush,
  input  logic        pipe_adv,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] M_load_data,
  output logic        mem_stall,
  output logic        M_adel,
  output logic        M_ades,
  output logic [31:0] M_badvaddr
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_e;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd2;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [5:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        kill_q, kill_d;

  logic        in_store, misalign, adel, ades, go, kill_now;
  logic [1:0]  in_size;
  logic [31:0] in_wdata, load_fmt;
  logic [3:0]  in_wstrb;

  // Decode and format the access currently presented by the MEM stage.
  always_comb begin
    in_store = is_store_op(M_master_op);
    in_size  = size_of(M_master_op);
    misalign = ((in_size == 2'd1) && M_master_alu_res[0]) ||
               ((in_size == 2'd2) && (M_master_alu_res[1:0] != 2'b00));
    adel     = M_master_mem_en && !in_store && misalign;
    ades     = M_master_mem_en && in_store && misalign;
    go       = M_master_mem_en && !adel && !ades && !flush;
    in_wdata = M_master_rt_value;
    in_wstrb = 4'b0000;
    case (M_master_op)
      OP_SB: begin
        in_wdata = {4{M_master_rt_value[7:0]}};
        in_wstrb = 4'b0001 << M_master_alu_res[1:0];
      end
      OP_SH: begin
        in_wdata = {2{M_master_rt_value[15:0]}};
        in_wstrb = M_master_alu_res[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW:   in_wstrb = 4'b1111;
      default: ;
    endcase
  end

  assign M_adel     = adel;
  assign M_ades     = ades;
  assign M_badvaddr = (adel || ades) ? M_master_alu_res : 32'd0;
  assign load_fmt   = fmt_load(op_q, addr_q[1:0], data_rdata);
  assign kill_now   = kill_q || flush;

  // NOTE: every output and _d signal gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    op_d        = op_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    kill_d      = kill_q;
    result_d    = result_q;
    data_req    = 1'b0;
    data_wr     = is_store_op(op_q);
    data_size   = size_q;
    data_addr   = addr_q;
    data_wdata  = wdata_q;
    data_wstrb  = wstrb_q;
    mem_stall   = 1'b0;
    M_load_data = result_q;
    unique case (state_q)
      IDLE: if (go) begin
        data_req   = 1'b1;
        data_wr    = in_store;
        data_size  = in_size;
        data_addr  = M_master_alu_res;
        data_wdata = in_wdata;
        data_wstrb = in_wstrb;
        mem_stall  = 1'b1;
        addr_d     = M_master_alu_res;
        op_d       = M_master_op;
        size_d     = in_size;
        wdata_d    = in_wdata;
        wstrb_d    = in_wstrb;
        kill_d     = 1'b0;
        state_d    = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
      end
      WAIT_ADDR: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        kill_d    = kill_now;
        if (data_addr_ok) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        mem_stall = 1'b1;
        kill_d    = kill_now;
        if (data_data_ok) begin
          // A killed transaction drains the bus but never reaches the pipeline.
          if (kill_now) begin
            M_load_data = 32'd0;
          end else begin
            M_load_data = load_fmt;
            result_d    = load_fmt;
            mem_stall   = 1'b0;
          end
          if (pipe_adv || kill_now) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: if (pipe_adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      data_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      op_q     <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      kill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      kill_q   <= kill_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: load/store formatting, address errors, bus
// handshakes, DONE hold, flush kill and asynchronous reset.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        M_master_mem_en;
  logic [5:0]  M_master_op;
  logic [31:0] M_master_alu_res, M_master_rt_value;
  logic        flush, pipe_adv;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, M_load_data;
  logic        mem_stall, M_adel, M_ades;
  logic [31:0] M_badvaddr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .M_master_mem_en(M_master_mem_en), .M_master_op(M_master_op),
    .M_master_alu_res(M_master_alu_res), .M_master_rt_value(M_master_rt_value),
    .flush(flush), .pipe_adv(pipe_adv),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .M_load_data(M_load_data), .mem_stall(mem_stall),
    .M_adel(M_adel), .M_ades(M_ades), .M_badvaddr(M_badvaddr)
  );

  task automatic idle_in();
    M_master_mem_en = 1'b0; M_master_op = 6'h00; M_master_alu_res = 32'd0;
    M_master_rt_value = 32'd0; flush = 1'b0; pipe_adv = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    M_master_mem_en = 1'b1; M_master_op = op; M_master_alu_res = addr; M_master_rt_value = rt;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b0;
    access(6'h23, 32'h100, 32'h0);
    data_addr_ok = 1'b1;
    #3;
    total_cnt++; if (data_req !== 1'b0) $display("FAIL reset_req: got %b want 0", data_req); else pass_cnt++;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else pass_cnt++;
    total_cnt++; if (M_load_data !== 32'd0) $display("FAIL reset_load: got %h want 0", M_load_data); else pass_cnt++;
    next_cycle(); next_cycle();
    idle_in();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_lb();
    int  stall_cnt = 0;
    logic bad = 1'b0;
    access(6'h20, 32'h1003, 32'h0);
    data_addr_ok = 1'b1;
    sample();
    total_cnt++;
    if ({data_req, data_wr, data_size, data_addr, data_wstrb} !== {1'b1, 1'b0, 2'd0, 32'h1003, 4'h0})
      $display("FAIL lb_issue: got req=%b wr=%b size=%0d addr=%h strb=%b want 1 0 0 00001003 0000",
               data_req, data_wr, data_size, data_addr, data_wstrb);
    else pass_cnt++;
    if (mem_stall) stall_cnt++;
    next_cycle();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      if (data_req !== 1'b0) bad = 1'b1;
      if (mem_stall) stall_cnt++;
      next_cycle();
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL lb_wait_req: got req during WAIT_DATA want none"); else pass_cnt++;
    data_data_ok = 1'b1; data_rdata = 32'h80AABBCC; pipe_adv = 1'b1;
    sample();
    total_cnt++; if (M_load_data !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", M_load_data); else pass_cnt++;
    if (mem_stall) stall_cnt++;
    next_cycle();
    idle_in();
    total_cnt++; if (stall_cnt !== 3) $display("FAIL lb_stall_cycles: got %0d want 3", stall_cnt); else pass_cnt++;
    sample();
    total_cnt++; if (M_load_data !== 32'hFFFFFF80) $display("FAIL lb_held: got %h want ffffff80", M_load_data); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_sh();
    int   req_cnt = 0;
    logic bad = 1'b0;
    access(6'h29, 32'h2002, 32'h1234ABCD);
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      if (i >= 1) begin
        M_master_alu_res = 32'h5554; M_master_rt_value = 32'hDEADBEEF;
      end
      sample();
      if (data_req) req_cnt++;
      if ({data_wr, data_size, data_addr, data_wdata, data_wstrb} !==
          {1'b1, 2'd1, 32'h2002, 32'hABCDABCD, 4'b1100}) begin
        bad = 1'b1;
        $display("FAIL sh_fields_c%0d: got wr=%b size=%0d addr=%h wdata=%h strb=%b want 1 1 00002002 abcdabcd 1100",
                 i, data_wr, data_size, data_addr, data_wdata, data_wstrb);
      end
      next_cycle();
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL sh_fields: got unstable bus fields want stable"); else pass_cnt++;
    total_cnt++; if (req_cnt !== 4) $display("FAIL sh_req_cycles: got %0d want 4", req_cnt); else pass_cnt++;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; pipe_adv = 1'b1;
    sample();
    total_cnt++; if ({data_req, mem_stall} !== 2'b00) $display("FAIL sh_done: got req/stall=%b%b want 00", data_req, mem_stall); else pass_cnt++;
    next_cycle();
    idle_in();
  endtask

  task automatic test_addr_err();
    access(6'h23, 32'h3001, 32'h0);
    data_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      total_cnt++;
      if ({M_adel, M_ades, M_badvaddr, data_req, mem_stall} !== {1'b1, 1'b0, 32'h3001, 1'b0, 1'b0})
        $display("FAIL lw_adel_c%0d: got adel=%b ades=%b bad=%h req=%b stall=%b want 1 0 00003001 0 0",
                 i, M_adel, M_ades, M_badvaddr, data_req, mem_stall);
      else pass_cnt++;
      next_cycle();
    end
    access(6'h2B, 32'h4002, 32'h0);
    sample();
    total_cnt++;
    if ({M_adel, M_ades, M_badvaddr, data_req} !== {1'b0, 1'b1, 32'h4002, 1'b0})
      $display("FAIL sw_ades: got adel=%b ades=%b bad=%h req=%b want 0 1 00004002 0", M_adel, M_ades, M_badvaddr, data_req);
    else pass_cnt++;
    access(6'h25, 32'h4001, 32'h0);
    sample();
    total_cnt++; if ({M_adel, M_ades, data_req} !== 3'b100) $display("FAIL lhu_adel: got %b%b%b want 100", M_adel, M_ades, data_req); else pass_cnt++;
    access(6'h23, 32'h3001, 32'h0);
    M_master_mem_en = 1'b0;
    sample();
    total_cnt++;
    if ({M_adel, M_ades, M_badvaddr} !== {2'b00, 32'd0})
      $display("FAIL err_unqualified: got adel=%b ades=%b bad=%h want 0 0 00000000", M_adel, M_ades, M_badvaddr);
    else pass_cnt++;
    next_cycle();
    idle_in();
  endtask

  task automatic test_done_hold();
    int   req_cnt = 0;
    logic bad = 1'b0;
    access(6'h25, 32'h6002, 32'h0);
    data_addr_ok = 1'b1;
    sample(); if (data_req) req_cnt++;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h98761234;
    sample(); if (data_req) req_cnt++;
    total_cnt++;
    if ({M_load_data, mem_stall} !== {32'h00009876, 1'b0})
      $display("FAIL lhu_data: got %h stall=%b want 00009876 0", M_load_data, mem_stall);
    else pass_cnt++;
    next_cycle();
    data_data_ok = 1'b0; data_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      pipe_adv = (i == 3);
      sample();
      if (data_req) req_cnt++;
      if (mem_stall !== 1'b0 || M_load_data !== 32'h00009876) bad = 1'b1;
      next_cycle();
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL done_hold: got stall or changed data want held 00009876 no stall"); else pass_cnt++;
    total_cnt++; if (req_cnt !== 1) $display("FAIL done_req_count: got %0d want 1", req_cnt); else pass_cnt++;
    idle_in();
  endtask

  task automatic test_back_to_back();
    access(6'h2B, 32'h7004, 32'hCAFEF00D);
    data_addr_ok = 1'b1;
    sample();
    total_cnt++;
    if ({data_req, data_wr, data_size, data_wdata, data_wstrb} !== {1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 4'hF})
      $display("FAIL sw_issue: got req=%b wr=%b size=%0d wdata=%h strb=%b want 1 1 2 cafef00d 1111",
               data_req, data_wr, data_size, data_wdata, data_wstrb);
    else pass_cnt++;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; pipe_adv = 1'b1;
    next_cycle();
    idle_in();
    access(6'h21, 32'h7000, 32'h0);
    data_addr_ok = 1'b1;
    sample();
    total_cnt++; if (data_req !== 1'b1) $display("FAIL lh_issue: got req=%b want 1", data_req); else pass_cnt++;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h00008001; pipe_adv = 1'b1;
    sample();
    total_cnt++; if (M_load_data !== 32'hFFFF8001) $display("FAIL lh_data: got %h want ffff8001", M_load_data); else pass_cnt++;
    next_cycle();
    idle_in();
  endtask

  task automatic test_flush();
    access(6'h23, 32'h8000, 32'h0);
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0; flush = 1'b1;
    sample();
    total_cnt++; if ({data_req, mem_stall} !== 2'b01) $display("FAIL flush_c1: got req/stall=%b%b want 01", data_req, mem_stall); else pass_cnt++;
    next_cycle();
    flush = 1'b0;
    access(6'h23, 32'hA000, 32'h0);
    sample();
    total_cnt++; if ({data_req, mem_stall} !== 2'b01) $display("FAIL flush_c2: got req/stall=%b%b want 01", data_req, mem_stall); else pass_cnt++;
    next_cycle();
    data_data_ok = 1'b1; data_rdata = 32'h11223344;
    sample();
    total_cnt++;
    if ({data_req, mem_stall, M_load_data} !== {2'b01, 32'd0})
      $display("FAIL flush_drop: got req=%b stall=%b data=%h want 0 1 00000000", data_req, mem_stall, M_load_data);
    else pass_cnt++;
    next_cycle();
    idle_in();
    sample();
    total_cnt++; if (M_load_data !== 32'hFFFF8001) $display("FAIL flush_result_kept: got %h want ffff8001", M_load_data); else pass_cnt++;
    next_cycle();
    access(6'h24, 32'h9001, 32'h0);
    data_addr_ok = 1'b1;
    sample();
    total_cnt++; if (data_req !== 1'b1) $display("FAIL flush_idle: got req=%b want 1", data_req); else pass_cnt++;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000F000; pipe_adv = 1'b1;
    sample();
    total_cnt++; if (M_load_data !== 32'h000000F0) $display("FAIL lbu_data: got %h want 000000f0", M_load_data); else pass_cnt++;
    next_cycle();
    idle_in();
  endtask

  task automatic test_reset_mid();
    access(6'h2B, 32'hB000, 32'h11111111);
    next_cycle();
    sample();
    total_cnt++; if (data_req !== 1'b1) $display("FAIL mid_wait_addr: got req=%b want 1", data_req); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({data_req, mem_stall, M_load_data} !== {2'b00, 32'd0})
      $display("FAIL mid_reset_async: got req=%b stall=%b data=%h want 0 0 00000000", data_req, mem_stall, M_load_data);
    else pass_cnt++;
    next_cycle();
    idle_in();
    #2 rst = 1'b1;
    access(6'h28, 32'hC003, 32'h000000A5);
    data_addr_ok = 1'b1;
    sample();
    total_cnt++;
    if ({data_req, data_addr, data_wdata, data_wstrb, data_size} !== {1'b1, 32'hC003, 32'hA5A5A5A5, 4'b1000, 2'd0})
      $display("FAIL sb_after_reset: got req=%b addr=%h wdata=%h strb=%b size=%0d want 1 0000c003 a5a5a5a5 1000 0",
               data_req, data_addr, data_wdata, data_wstrb, data_size);
    else pass_cnt++;
    next_cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; pipe_adv = 1'b1;
    next_cycle();
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_addr_err();
    test_done_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
